// File: rtl/lib_pkt_source_pkg.sv
// Shared types and constants for the packet source (lib_pkt_source and lib_lfsr).
// The LFSR tap table is only used when LIB_PKT_SOURCE_LFSR_EN is defined.
package lib_pkt_source_pkg;

  localparam int PKT_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Maximal-length Fibonacci feedback taps (bit n-1 set for tap n), widths 4..16.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      4:       lfsr_taps = 32'h0000_000C;
      5:       lfsr_taps = 32'h0000_0014;
      6:       lfsr_taps = 32'h0000_0030;
      7:       lfsr_taps = 32'h0000_0060;
      8:       lfsr_taps = 32'h0000_00B8;
      9:       lfsr_taps = 32'h0000_0110;
      10:      lfsr_taps = 32'h0000_0240;
      11:      lfsr_taps = 32'h0000_0500;
      12:      lfsr_taps = 32'h0000_0829;
      13:      lfsr_taps = 32'h0000_100D;
      14:      lfsr_taps = 32'h0000_2015;
      15:      lfsr_taps = 32'h0000_6000;
      default: lfsr_taps = 32'h0000_D008;
    endcase
  endfunction

endpackage

// File: rtl/lib_pkt_source_if.sv
// Word stream from lib_pkt_source to a downstream FIFO.
interface lib_pkt_source_if #(parameter int WIDTH = 4);

  // Handshake: a word transfers on the rising clk edge where o_data_val && i_en;
  // while o_data_val is high and i_en low, o_data/o_sop/o_eop hold unchanged.
  logic [WIDTH-1:0] o_data;
  logic             o_data_val;
  logic             o_sop;
  logic             o_eop;
  logic             i_en;

  modport master (output o_data, output o_data_val, output o_sop, output o_eop, input i_en);
  modport slave  (input o_data, input o_data_val, input o_sop, input o_eop, output i_en);

endinterface

// File: rtl/lib_pkt_source_lfsr.sv
// lib_lfsr: WIDTH-bit maximal-length Fibonacci LFSR, seeded all-ones, steps on i_step.
// Compiled only when LIB_PKT_SOURCE_LFSR_EN is defined.
`ifdef LIB_PKT_SOURCE_LFSR_EN
module lib_lfsr
  import lib_pkt_source_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_value
);

  localparam logic [31:0]      TAPS_ALL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_value <= '1;
    end else if (i_step) begin
      o_value <= {o_value[WIDTH-2:0], ^(o_value & TAPS)};
    end
  end

endmodule
`endif

// File: rtl/lib_pkt_source.sv
// Packet source: header = sequence number, then PKT_LEN-1 payload words, GAP idle cycles.
// Define LIB_PKT_SOURCE_LFSR_EN to take payload words from lib_lfsr instead of a counter.
module lib_pkt_source
  import lib_pkt_source_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int PKT_LEN = 4,
  parameter int GAP     = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_run,
  lib_pkt_source_if.master      bus,
  output logic [PKT_CNT_W-1:0]  o_pkt_cnt,
  output logic                  o_busy,
  output state_t                o_state
);

  localparam int               IDX_W    = $clog2(PKT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
  localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]     seq_q, seq_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [PKT_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     data_q;
  logic                 val_q, sop_q, eop_q, busy_q;
  logic                 accept, load;
  logic [WIDTH-1:0]     payload, word_d;

  assign accept = (state_q == ST_SEND) && bus.i_en;
  // A new word enters the output register on entry to SEND or after each accepted word.
  assign load   = (state_d == ST_SEND) && ((state_q != ST_SEND) || accept);

`ifdef LIB_PKT_SOURCE_LFSR_EN
  logic             lfsr_step;
  logic [WIDTH-1:0] lfsr_value;

  // Every loaded payload word is later accepted (or wiped by reset, which reseeds),
  // so stepping on load advances the LFSR exactly once per accepted payload word.
  assign lfsr_step = load && (idx_d != '0);
  assign payload   = lfsr_value;

  lib_lfsr #(.WIDTH(WIDTH)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_step  (lfsr_step),
    .o_value (lfsr_value)
  );
`else
  assign payload = WIDTH'(32'(idx_d) - 32'd1);
`endif

  assign word_d = (idx_d == '0) ? seq_d : payload;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      seq_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seq_d   = seq_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_run) begin
          state_d = ST_SEND;
          idx_d   = '0;
        end
      end
      ST_SEND: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            seq_d = seq_q + 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (GAP > 0) begin
              state_d = ST_GAP;
              gap_d   = '0;
            end else if (!i_run) begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = i_run ? ST_SEND : ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      val_q  <= 1'b0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      data_q <= load ? word_d : ((state_d == ST_SEND) ? data_q : '0);
      val_q  <= (state_d == ST_SEND);
      sop_q  <= (state_d == ST_SEND) && (idx_d == '0);
      eop_q  <= (state_d == ST_SEND) && (idx_d == LAST_IDX);
      busy_q <= (state_d != ST_IDLE);
    end
  end

  assign bus.o_data     = data_q;
  assign bus.o_data_val = val_q;
  assign bus.o_sop      = sop_q;
  assign bus.o_eop      = eop_q;
  assign o_pkt_cnt      = cnt_q;
  assign o_busy         = busy_q;
  assign o_state        = state_q;

endmodule

// File: doc/lib_pkt_source.md
LIB_PKT_SOURCE -- requirements
Module: LIB_PKT_SOURCE

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data word width in bits (min 4).
REQ-002 SHALL have parameter PKT_LEN, default 4, words per packet including header (min 2).
REQ-003 SHALL have parameter GAP, default 1, idle cycles between packets (0 allowed).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_run  input  1  level; high enables packet generation.
REQ-007 SHALL have port i_en  input  1  downstream ready (FIFO not full); transfer on clk edge when o_data_val && i_en.
REQ-008 SHALL have port o_data  output  WIDTH  word offered to the downstream FIFO.
REQ-009 SHALL have port o_data_val  output  1  o_data is valid.
REQ-010 SHALL have port o_sop  output  1  current word is a packet header.
REQ-011 SHALL have port o_eop  output  1  current word is the last packet word.
REQ-012 SHALL have port o_pkt_cnt  output  16  completed packets, wraps at 2^16.
REQ-013 SHALL have port o_busy  output  1  high while not in IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SEND, GAP.
REQ-015 IDLE -> SEND on the first edge with i_run=1; otherwise stay in IDLE.
REQ-016 In SEND, o_data_val=1 and o_sop/o_eop mark word index 0 and PKT_LEN-1.
REQ-017 Header word SHALL be the packet sequence number, modulo 2^WIDTH, starting at 0 after reset.
REQ-018 Payload word k (k=1..PKT_LEN-1) SHALL be (k-1) modulo 2^WIDTH unless the LFSR feature is compiled in (REQ-029).
REQ-019 While o_data_val=1 and i_en=0, o_data, o_sop and o_eop SHALL hold unchanged (no drop, no skip).
REQ-020 The word index SHALL advance only on an accepted transfer; one word per cycle maximum, zero-cycle latency from i_en to acceptance.
REQ-021 On acceptance of the o_eop word: o_pkt_cnt increments, the sequence number increments, and the state moves to GAP if GAP>0, else back to SEND if i_run=1, else IDLE.
REQ-022 GAP SHALL count exactly GAP cycles with o_data_val=0, then go to SEND if i_run=1, else IDLE.
REQ-023 Deasserting i_run mid-packet SHALL NOT truncate the packet; the FSM stops only at a packet boundary.
REQ-024 o_data SHALL be 0 whenever o_data_val=0.

Reset
REQ-025 Reset SHALL force: state IDLE, o_data=0, o_data_val=0, o_sop=0, o_eop=0, o_pkt_cnt=0, o_busy=0, sequence=0, word index=0, gap counter=0.
REQ-026 Reset asserted mid-packet SHALL abandon the packet immediately; after release the first packet SHALL have sequence 0.
REQ-027 All outputs SHALL be registered.

Configuration
REQ-028 Macro LIB_PKT_SOURCE_LFSR_EN SHALL select the payload generator.
REQ-029 With the macro defined, payload words SHALL come from a WIDTH-bit maximal-length Fibonacci LFSR, seeded to all-ones at reset, advanced once per accepted payload word, never reseeded between packets.
REQ-030 Without the macro, the LFSR logic SHALL be absent and REQ-018 applies.

Structure
REQ-031 The FSM state enum and the o_pkt_cnt width constant (16) SHALL live in the shared LIB package.
REQ-032 The LFSR SHALL be a sub-module named LIB_LFSR (parameter WIDTH; ports clk, reset_n, i_step, o_value), instantiated only under LIB_PKT_SOURCE_LFSR_EN.

Verification
REQ-033 Reset release with i_run=1, i_en=1, WIDTH=4, PKT_LEN=4, GAP=1 -> words 0,0,1,2 (sop on the first, eop on the last), 1 idle cycle, then 1,0,1,2; o_pkt_cnt 1 then 2.
REQ-034 i_en=0 for 3 cycles while the second word is offered -> o_data=0 held 3 cycles, no duplicate or missing word, packet completes normally.
REQ-035 i_run dropped after the header is accepted -> remaining 3 words sent, then IDLE, o_busy=0, no further o_data_val.
REQ-036 GAP=0, i_run=1, i_en=1 for 8 cycles -> back-to-back packets, sequence 0 then 1, o_pkt_cnt=2.
REQ-037 reset_n pulsed low mid-packet -> outputs 0 asynchronously; next packet header is 0.
REQ-038 LIB_PKT_SOURCE_LFSR_EN defined, WIDTH=4 -> 15 consecutive payload words are distinct and non-zero, and the sequence repeats on the 16th word.
